kmeans_centroid_div: RTL



---
 rtl/kmeans_centroid_div_if.sv | 26 ++
 rtl/kmeans_centroid_div.sv | 114 +++++++++++
 2 files changed

// File: rtl/kmeans_centroid_div_if.sv
// Handshake bundle for the k-means centroid divider:
// operand request channel and result response channel.
interface kmeans_centroid_div_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 7
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVIDEND_WIDTH-1:0] remainder;
    logic                      div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/kmeans_centroid_div.sv
// Sequential signed-by-unsigned restoring divider for centroid update:
// one shift-subtract step per clock, C truncating semantics.
module kmeans_centroid_div #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 7
) (
    input logic                  ap_clk,
    input logic                  ap_rst,
    kmeans_centroid_div_if.slave bus
);
    localparam int W  = DIVIDEND_WIDTH;
    localparam int D  = DIVISOR_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [W-1:0]  mag;
    logic [D:0]    prem;
    logic [D-1:0]  dvsr;
    logic          neg;
    logic [CW-1:0] cnt;

    logic [W-1:0] q_r;
    logic [W-1:0] r_r;
    logic         dbz_r;

    logic         take;
    logic [W-1:0] abs_in;
    logic [D:0]   prem_sh;
    logic [D:0]   prem_sub;
    logic         ge;
    logic [W-1:0] q_nx;
    logic [W-1:0] r_ext;

    assign take   = bus.in_valid && bus.in_ready;
    assign abs_in = bus.dividend[W-1] ? (~bus.dividend + 1'b1) : bus.dividend;

    // Magnitude register doubles as the quotient: MSBs shift out, quotient bits shift in.
    always_comb begin
        prem_sh  = {prem[D-1:0], mag[W-1]};
        ge       = (prem_sh >= {1'b0, dvsr});
        prem_sub = ge ? (prem_sh - {1'b0, dvsr}) : prem_sh;
        q_nx     = {mag[W-2:0], ge};
        r_ext    = W'(prem_sub[D-1:0]);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (take) state_nx = (bus.divisor == '0) ? DONE : RUN;
            RUN:  if (cnt == '0) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            mag   <= '0;
            prem  <= '0;
            dvsr  <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        mag  <= abs_in;
                        neg  <= bus.dividend[W-1];
                        dvsr <= bus.divisor;
                        prem <= '0;
                        cnt  <= CW'(W - 1);
                        if (bus.divisor == '0) begin
                            q_r   <= '0;
                            r_r   <= '0;
                            dbz_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    mag  <= q_nx;
                    prem <= prem_sub;
                    cnt  <= cnt - 1'b1;
                    // Remainder follows the dividend's sign.
                    if (cnt == '0) begin
                        q_r   <= neg ? (~q_nx + 1'b1) : q_nx;
                        r_r   <= neg ? (~r_ext + 1'b1) : r_ext;
                        dbz_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = q_r;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = dbz_r;
endmodule
